// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule into an 11-entry round-key store; define KEYEXP_ZEROIZE_EN to clear the store on reset
module aes_key_expander (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t       state;
  logic [127:0] store [11];
  logic [127:0] work, next_work;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic [31:0]  rot, t, w0, w1, w2, w3;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the field inverse (and maps 0 to 0), followed by the FIPS-197 affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), x);
    r = gmul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  always_comb begin
    rot = {work[23:0], work[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h0};
    w0 = work[127:96] ^ t;
    w1 = work[95:64] ^ w0;
    w2 = work[63:32] ^ w1;
    w3 = work[31:0] ^ w2;
    next_work = {w0, w1, w2, w3};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      valid  <= 1'b0;
      round  <= 4'd0;
      rcon   <= 8'h01;
      rd_key <= '0;
`ifdef KEYEXP_ZEROIZE_EN
      work <= '0;
      for (int i = 0; i < 11; i++) store[i] <= '0;
`endif
    end else begin
      rd_key <= (rd_idx <= 4'd10) ? store[rd_idx] : '0;
      done   <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          store[0] <= key;
          work     <= key;
          rcon     <= 8'h01;
          round    <= 4'd1;
          busy     <= 1'b1;
          valid    <= 1'b0;
          state    <= EXPAND;
        end
      end else begin
        store[round] <= next_work;
        work         <= next_work;
        rcon         <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        round        <= round + 4'd1;
        if (round == 4'd10) begin
          busy  <= 1'b0;
          valid <= 1'b1;
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: random and FIPS-197 keys checked against a word-level key schedule model
module tb_aes_key_expander;
  logic         clock = 0, reset = 1, start = 0;
  logic [127:0] key = '0;
  logic         busy, done, valid;
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;
  int           tests = 0, fails = 0;
  logic [7:0]   sb [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] mrk [11];
  logic [127:0] rd;
  aes_key_expander dut (
    .clock(clock), .reset(reset), .start(start), .key(key),
    .busy(busy), .done(done), .valid(valid), .rd_idx(rd_idx), .rd_key(rd_key)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11b << (i - 8);
    return p[7:0];
  endfunction
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] a, s, c;
    a = '0;
    c = 8'h63;
    for (int y = 1; y < 256; y++) if (pmul(x, 8'(y)) == 8'h01) a = 8'(y);
    for (int i = 0; i < 8; i++) s[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8] ^ a[(i + 7) % 8] ^ c[i];
    return s;
  endfunction
  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rcon_tab[i / 4 - 1], 24'h0};
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) mrk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic read_key(input int idx, output logic [127:0] v);
    rd_idx = 4'(idx);
    tick();
    v = rd_key;
  endtask
  task automatic launch(input logic [127:0] k, input bit glitch);
    int n;
    key = k;
    start = 1;
    tick();
    start = 0;
    check("busy_after_start", busy, 1);
    check("valid_after_start", valid, 0);
    n = 0;
    while (!done && n < 20) begin
      start = glitch && (n == 2 || n == 6);
      key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    start = 0;
    check("latency", n, 10);
    check("valid_at_done", valid, 1);
    check("busy_at_done", busy, 0);
  endtask
  task automatic check_all(input logic [127:0] k);
    model(k);
    for (int i = 0; i < 11; i++) begin
      read_key(i, rd);
      check($sformatf("rk%0d", i), rd, mrk[i]);
    end
  endtask
  initial begin
    logic [127:0] k1, k2;
    for (int x = 0; x < 256; x++) sb[x] = ref_sbox(8'(x));
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_rd_key", rd_key, 0);
    start = 1;
    key = 128'h1;
    tick();
    reset = 0;
    start = 0;
    check("rst_over_start", busy, 0);
    k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    launch(k1, 0);
    tick();
    check("done_pulse", done, 0);
    read_key(1, rd);
    check("fips_rk1", rd, 128'ha0fafe1788542cb123a339392a6c7605);
    read_key(10, rd);
    check("fips_rk10", rd, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_key(0, rd);
    check("fips_rk0", rd, k1);
    check_all(k1);
    read_key(11, rd);
    check("idx11", rd, 0);
    read_key(15, rd);
    check("idx15", rd, 0);
    launch('0, 0);
    read_key(1, rd);
    check("zero_rk1", rd, 128'h62636363626363636263636362636363);
    read_key(10, rd);
    check("zero_rk10", rd, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    k1 = {$urandom, $urandom, $urandom, $urandom};
    launch(k1, 1);
    check_all(k1);
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    launch(k1, 0);
    launch(k2, 0);
    check_all(k2);
    k1 = {$urandom, $urandom, $urandom, $urandom};
    key = k1;
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    reset = 1;
    tick();
    reset = 0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check("midrst_done", done, 0);
`ifdef KEYEXP_ZEROIZE_EN
    for (int i = 0; i < 11; i++) begin
      read_key(i, rd);
      check($sformatf("zeroize%0d", i), rd, 0);
    end
`else
    model(k1);
    for (int i = 0; i < 5; i++) begin
      read_key(i, rd);
      check($sformatf("partial%0d", i), rd, mrk[i]);
    end
`endif
    k2 = {$urandom, $urandom, $urandom, $urandom};
    launch(k2, 0);
    check_all(k2);
    repeat (3) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      launch(k1, 0);
      check_all(k1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
